// File: rtl/add_sum_collector_if.sv
// Handshake bundle between the adder stream and the window collector.
// master: the sample producer / result consumer; slave: the collector.
interface add_sum_collector_if #(
  parameter int unsigned SUM_W = 5,
  parameter int unsigned ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [SUM_W-1:0] out_max;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_max, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_max, out_ovf
  );
endinterface

// File: rtl/add_sum_collector.sv
// add_sum_collector: accumulates windows of WINDOW adder sums and holds the
// window total and maximum until downstream accepts them.
// Optional feature macro: ADD_SUM_COLLECT_SAT_EN (saturating accumulator
// with overflow flag); when undefined the accumulator wraps and out_ovf is 0.
module add_sum_collector #(
  parameter int unsigned SUM_W  = 5,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  add_sum_collector_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] maxv_q, maxv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [SUM_W-1:0] omax_q, omax_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             last_c;
  logic [ACC_W-1:0] sample_ext_c;
  logic [ACC_W-1:0] acc_new_c;
  logic [SUM_W-1:0] max_new_c;

`ifdef ADD_SUM_COLLECT_SAT_EN
  logic             ovf_q, ovf_d;
  logic             oovf_q, oovf_d;
  logic [ACC_W:0]   sum_wide_c;
  logic             ovf_new_c;
`endif

  // Ready whenever collecting, or in HOLD when the result drains this cycle.
  assign in_ready_c = (state_q == S_ACCUM) || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign last_c     = (cnt_q == CNT_W'(WINDOW - 1));

  // Next accumulator value and running maximum for the incoming sample.
  always_comb begin
    sample_ext_c = ACC_W'(bus.in_sum);
`ifdef ADD_SUM_COLLECT_SAT_EN
    sum_wide_c = {1'b0, acc_q} + {1'b0, sample_ext_c};
    acc_new_c  = sum_wide_c[ACC_W] ? {ACC_W{1'b1}} : sum_wide_c[ACC_W-1:0];
    ovf_new_c  = ovf_q | sum_wide_c[ACC_W];
`else
    acc_new_c  = acc_q + sample_ext_c;
`endif
    max_new_c = (bus.in_sum > maxv_q) ? bus.in_sum : maxv_q;
  end

  // Next-state and datapath update; HOLD always holds a cleared window, so a
  // sample accepted during the draining cycle starts the next window.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    maxv_d  = maxv_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    omax_d  = omax_q;
`ifdef ADD_SUM_COLLECT_SAT_EN
    ovf_d   = ovf_q;
    oovf_d  = oovf_q;
`endif

    unique case (state_q)
      S_ACCUM: begin
        if (accept_c) begin
          if (last_c) begin
            total_d = acc_new_c;
            omax_d  = max_new_c;
            acc_d   = '0;
            maxv_d  = '0;
            cnt_d   = '0;
`ifdef ADD_SUM_COLLECT_SAT_EN
            oovf_d  = ovf_new_c;
            ovf_d   = 1'b0;
`endif
            state_d = S_HOLD;
          end else begin
            acc_d  = acc_new_c;
            maxv_d = max_new_c;
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef ADD_SUM_COLLECT_SAT_EN
            ovf_d  = ovf_new_c;
`endif
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_ACCUM;
          if (bus.in_valid) begin
            acc_d  = acc_new_c;
            maxv_d = max_new_c;
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef ADD_SUM_COLLECT_SAT_EN
            ovf_d  = ovf_new_c;
`endif
          end
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACCUM;
      acc_q   <= '0;
      maxv_q  <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      omax_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      maxv_q  <= maxv_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      omax_q  <= omax_d;
    end
  end

`ifdef ADD_SUM_COLLECT_SAT_EN
  // Overflow flags for the running window and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      oovf_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      oovf_q <= oovf_d;
    end
  end

  assign bus.out_ovf = oovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_total = total_q;
  assign bus.out_max   = omax_q;

endmodule

// File: tb/tb_add_sum_collector.sv
// Directed scoreboard bench for add_sum_collector (default and ACC_W=6 builds).
module tb_add_sum_collector;

  typedef struct packed {
    logic [7:0] total;
    logic [4:0] max;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  add_sum_collector_if #(.SUM_W(5), .ACC_W(8)) bus  ();
  add_sum_collector_if #(.SUM_W(5), .ACC_W(6)) bus6 ();

  add_sum_collector #(.SUM_W(5), .WINDOW(4), .ACC_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  add_sum_collector #(.SUM_W(5), .WINDOW(4), .ACC_W(6)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] t, input logic [4:0] m, input logic o);
    exp_t e;
    e.total = t;
    e.max   = m;
    e.ovf   = o;
    sb_q.push_back(e);
  endtask

  // Compare a consumed result against the head of the scoreboard.
  task automatic pop_check();
    exp_t e;
    chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("out_total", 32'(bus.out_total), 32'(e.total));
      chk("out_max",   32'(bus.out_max),   32'(e.max));
      chk("out_ovf",   32'(bus.out_ovf),   32'(e.ovf));
    end
  endtask

  // One clock of stimulus on the main DUT; reports whether the sample was taken.
  task automatic cyc(input logic v, input logic [4:0] s, input logic ordy, output logic acc);
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.out_ready = ordy;
    @(negedge clk);
    acc = v && bus.in_ready;
    if (bus.out_valid && ordy) pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_total"}, 32'(bus.out_total), 32'd0);
    chk({tag, "_out_max"},   32'(bus.out_max),   32'd0);
    chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
  endtask

  initial begin
    logic       a;
    logic [4:0] basic [4];
    logic [7:0] exp6_total;
    logic       exp6_ovf;

    checks = 0;
    errors = 0;
    basic[0] = 5'd6; basic[1] = 5'd6; basic[2] = 5'd8; basic[3] = 5'd9;

    bus.in_valid   = 1'b0;
    bus.in_sum     = '0;
    bus.out_ready  = 1'b1;
    bus6.in_valid  = 1'b0;
    bus6.in_sum    = '0;
    bus6.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic window
    push_exp(8'd29, 5'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, basic[i], 1'b1, a);
      chk("basic_accept", 32'(a), 32'd1);
    end
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    cyc(1'b0, 5'd0, 1'b1, a);
    chk("basic_valid_drop", 32'(bus.out_valid), 32'd0);

    // Backpressure: result frozen, no samples taken
    push_exp(8'd29, 5'd9, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, basic[i], 1'b1, a);
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2), 5'd7, 1'b0, a);
      chk("bp_no_accept", 32'(a), 32'd0);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_total",     32'(bus.out_total), 32'd29);
      chk("bp_max",       32'(bus.out_max),   32'd9);
    end
    cyc(1'b0, 5'd0, 1'b1, a);
    chk("bp_ready_back", 32'(bus.in_ready),  32'd1);
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);

    // Zero-bubble: 8 samples in 8 cycles
    push_exp(8'd10, 5'd4, 1'b0);
    push_exp(8'd26, 5'd8, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) chk("zb_valid_at_5th", 32'(bus.out_valid), 32'd1);
      cyc(1'b1, 5'(i), 1'b1, a);
      chk("zb_accept", 32'(a), 32'd1);
    end
    cyc(1'b0, 5'd0, 1'b1, a);
    chk("zb_drained", 32'(sb_q.size()), 32'd0);

    // Gapped input
    push_exp(8'd36, 5'd31, 1'b0);
    cyc(1'b1, 5'd3, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);
    cyc(1'b1, 5'd0, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);
    chk("gap_no_valid", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 5'd31, 1'b1, a);
    cyc(1'b1, 5'd2, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);

    // Overflow on the ACC_W=6 instance
`ifdef ADD_SUM_COLLECT_SAT_EN
    exp6_total = 8'd63;
    exp6_ovf   = 1'b1;
`else
    exp6_total = 8'd60;
    exp6_ovf   = 1'b0;
`endif
    bus6.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus6.in_valid = 1'b1;
      bus6.in_sum   = 5'd31;
      @(posedge clk);
      #1;
    end
    bus6.in_valid = 1'b0;
    chk("ovf_valid", 32'(bus6.out_valid), 32'd1);
    chk("ovf_total", 32'(bus6.out_total), 32'(exp6_total));
    chk("ovf_flag",  32'(bus6.out_ovf),   32'(exp6_ovf));
    chk("ovf_max",   32'(bus6.out_max),   32'd31);
    bus6.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus6.in_valid = 1'b1;
      bus6.in_sum   = 5'd1;
      @(posedge clk);
      #1;
    end
    bus6.in_valid  = 1'b0;
    bus6.out_ready = 1'b0;
    chk("ovf2_valid", 32'(bus6.out_valid), 32'd1);
    chk("ovf2_total", 32'(bus6.out_total), 32'd4);
    chk("ovf2_flag",  32'(bus6.out_ovf),   32'd0);
    bus6.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-window
    cyc(1'b1, 5'd5, 1'b1, a);
    cyc(1'b1, 5'd9, 1'b1, a);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(8'd20, 5'd5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd5, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);

    // Reset while holding a result
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd7, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b0, a);
    chk("hold_before_rst", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(8'd20, 5'd5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd5, 1'b1, a);
    cyc(1'b0, 5'd0, 1'b1, a);

    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
